// File: rtl/scroll_msg_sequencer_if.sv
// Scroller sequencer bus: buttons/tick/switch data in, BRAM and shifter controls out.
// master drives the inputs (board glue), slave is the sequencer; SCROLL_PAUSE_EN adds pause_btn.
interface scroll_msg_sequencer_if;
  logic        prog_btn;
  logic        write_btn;
  logic        tick;
  logic [15:0] sw_data;
`ifdef SCROLL_PAUSE_EN
  logic        pause_btn;
`endif
  logic        wea;
  logic [1:0]  addra;
  logic [15:0] dina;
  logic        addrb;
  logic        load_en;
  logic        shift_en;
  logic        prog_mode;
  logic        cur_msg;

`ifdef SCROLL_PAUSE_EN
  modport master (
    output prog_btn, write_btn, tick, sw_data, pause_btn,
    input  wea, addra, dina, addrb,
    input  load_en, shift_en, prog_mode, cur_msg
  );
  modport slave (
    input  prog_btn, write_btn, tick, sw_data, pause_btn,
    output wea, addra, dina, addrb,
    output load_en, shift_en, prog_mode, cur_msg
  );
`else
  modport master (
    output prog_btn, write_btn, tick, sw_data,
    input  wea, addra, dina, addrb,
    input  load_en, shift_en, prog_mode, cur_msg
  );
  modport slave (
    input  prog_btn, write_btn, tick, sw_data,
    output wea, addra, dina, addrb,
    output load_en, shift_en, prog_mode, cur_msg
  );
`endif
endinterface

// File: rtl/scroll_msg_sequencer.sv
// Scroller controller: programs 4 halfwords into the message BRAM, then fetches/loads/scrolls
// msg0/msg1 alternately. Ports: CLK100MHZ, CPU_RESETN (async low), bus (slave). Option: SCROLL_PAUSE_EN.
module scroll_msg_sequencer #(
  parameter int READ_LAT       = 2,
  parameter int SHIFTS_PER_MSG = 8
) (
  input  logic CLK100MHZ,
  input  logic CPU_RESETN,
  scroll_msg_sequencer_if.slave bus
);

  localparam int FW = (READ_LAT < 1) ? 1 : $clog2(READ_LAT + 1);
  localparam int SW = (SHIFTS_PER_MSG < 2) ? 1 : $clog2(SHIFTS_PER_MSG);

  typedef enum logic [1:0] {
    S_FETCH, S_LOAD, S_RUN, S_PROG
  } state_e;

  state_e        state_q, state_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic [SW-1:0] scnt_q, scnt_d;
  logic [1:0]    widx_q, widx_d;
  logic          cur_q, cur_d;
  logic          paused_q, paused_d;

  logic          wea_q, wea_d;
  logic [1:0]    addra_q, addra_d;
  logic [15:0]   dina_q, dina_d;
  logic          addrb_q, addrb_d;
  logic          load_q, load_d;
  logic          shift_q, shift_d;
  logic          prog_q, prog_d;

  logic          pause_hit;
`ifdef SCROLL_PAUSE_EN
  assign pause_hit = bus.pause_btn;
`else
  assign pause_hit = 1'b0;
`endif

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      state_q  <= S_FETCH;
      fcnt_q   <= '0;
      scnt_q   <= '0;
      widx_q   <= '0;
      cur_q    <= 1'b0;
      paused_q <= 1'b0;
      wea_q    <= 1'b0;
      addra_q  <= '0;
      dina_q   <= '0;
      addrb_q  <= 1'b0;
      load_q   <= 1'b0;
      shift_q  <= 1'b0;
      prog_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      fcnt_q   <= fcnt_d;
      scnt_q   <= scnt_d;
      widx_q   <= widx_d;
      cur_q    <= cur_d;
      paused_q <= paused_d;
      wea_q    <= wea_d;
      addra_q  <= addra_d;
      dina_q   <= dina_d;
      addrb_q  <= addrb_d;
      load_q   <= load_d;
      shift_q  <= shift_d;
      prog_q   <= prog_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    fcnt_d   = '0;
    scnt_d   = scnt_q;
    widx_d   = widx_q;
    cur_d    = cur_q;
    paused_d = paused_q;
    unique case (state_q)
      S_FETCH: begin
        if (bus.prog_btn) begin
          state_d = S_PROG;
          widx_d  = '0;
        end else if (fcnt_q == FW'(READ_LAT)) begin
          state_d = S_LOAD;
        end else begin
          fcnt_d = fcnt_q + FW'(1);
        end
      end
      S_LOAD: begin
        if (bus.prog_btn) begin
          state_d = S_PROG;
          widx_d  = '0;
        end else begin
          state_d = S_RUN;
          scnt_d  = '0;
        end
      end
      S_RUN: begin
        if (bus.prog_btn) begin
          state_d = S_PROG;
          widx_d  = '0;
        end else begin
          if (bus.tick && !paused_q) begin
            if (scnt_q == SW'(SHIFTS_PER_MSG - 1)) begin
              cur_d   = ~cur_q;
              scnt_d  = '0;
              state_d = S_FETCH;
            end else begin
              scnt_d = scnt_q + SW'(1);
            end
          end
          if (pause_hit)
            paused_d = ~paused_q;
        end
      end
      S_PROG: begin
        if (bus.prog_btn) begin
          state_d = S_FETCH;
        end else if (bus.write_btn) begin
          widx_d = widx_q + 2'd1;
          if (widx_q == 2'd3) begin
            state_d = S_FETCH;
            cur_d   = 1'b0;
          end
        end
      end
      default: state_d = S_FETCH;
    endcase
    if (state_d == S_PROG)
      paused_d = 1'b0;
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_comb begin
    wea_d   = 1'b0;
    addra_d = addra_q;
    dina_d  = dina_q;
    if (state_q == S_PROG && !bus.prog_btn && bus.write_btn) begin
      wea_d   = 1'b1;
      addra_d = widx_q;
      dina_d  = bus.sw_data;
    end
    addrb_d = cur_d;
    load_d  = (state_d == S_LOAD);
    shift_d = (state_d == S_RUN) && !paused_d;
    prog_d  = (state_d == S_PROG);
  end

  assign bus.wea       = wea_q;
  assign bus.addra     = addra_q;
  assign bus.dina      = dina_q;
  assign bus.addrb     = addrb_q;
  assign bus.load_en   = load_q;
  assign bus.shift_en  = shift_q;
  assign bus.prog_mode = prog_q;
  assign bus.cur_msg   = cur_q;

endmodule

// File: tb/tb_scroll_msg_sequencer.sv
// Directed bench for scroll_msg_sequencer: reset, fetch/load/scroll, programming, abort, reset mid-write.
// Drives inputs #1 after the rising edge and samples outputs at the same point.
module tb_scroll_msg_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  scroll_msg_sequencer_if sif();

  scroll_msg_sequencer #(
    .READ_LAT(2),
    .SHIFTS_PER_MSG(8)
  ) dut (
    .CLK100MHZ(clk),
    .CPU_RESETN(rst_n),
    .bus(sif)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      step();
      sif.tick = 1'b1;
      step();
      sif.tick = 1'b0;
    end
  endtask

  task automatic wait_load(input string tag);
    int cyc = 0;
    while (!sif.load_en && cyc < 20) begin
      step();
      cyc++;
    end
    chk(tag, cyc, 3);
  endtask

  task automatic wr(input logic [15:0] d);
    sif.sw_data   = d;
    sif.write_btn = 1'b1;
    step();
    sif.write_btn = 1'b0;
  endtask

  task automatic prog();
    sif.prog_btn = 1'b1;
    step();
    sif.prog_btn = 1'b0;
  endtask

  logic [15:0] vals [4];

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    vals[0] = 16'h1234;
    vals[1] = 16'h5678;
    vals[2] = 16'h9ABC;
    vals[3] = 16'hDEF0;
    sif.prog_btn  = 1'b0;
    sif.write_btn = 1'b0;
    sif.tick      = 1'b0;
    sif.sw_data   = 16'h0;
`ifdef SCROLL_PAUSE_EN
    sif.pause_btn = 1'b0;
`endif
    repeat (2) step();
    chk("rst_wea", sif.wea, 0);
    chk("rst_addra", sif.addra, 0);
    chk("rst_dina", sif.dina, 0);
    chk("rst_addrb", sif.addrb, 0);
    chk("rst_load", sif.load_en, 0);
    chk("rst_shift", sif.shift_en, 0);
    chk("rst_prog", sif.prog_mode, 0);
    chk("rst_cur", sif.cur_msg, 0);

    rst_n = 1'b1;
    sif.tick = 1'b1;
    step();
    step();
    chk("t1_load_early", sif.load_en, 0);
    step();
    chk("t1_load", sif.load_en, 1);
    chk("t1_addrb", sif.addrb, 0);
    step();
    sif.tick = 1'b0;
    chk("t1_load_once", sif.load_en, 0);
    chk("t1_shift", sif.shift_en, 1);
    chk("t1_cur", sif.cur_msg, 0);

    ticks(7);
    chk("t2_cur7", sif.cur_msg, 0);
    chk("t2_shift7", sif.shift_en, 1);
    ticks(1);
    chk("t2_cur8", sif.cur_msg, 1);
    chk("t2_addrb", sif.addrb, 1);
    chk("t2_shift_off", sif.shift_en, 0);
    sif.tick = 1'b1;
    step();
    step();
    chk("t2_load_early", sif.load_en, 0);
    step();
    chk("t2_load", sif.load_en, 1);
    step();
    sif.tick = 1'b0;
    chk("t2_shift_on", sif.shift_en, 1);
    ticks(7);
    chk("t2_back7", sif.cur_msg, 1);
    ticks(1);
    chk("t2_back8", sif.cur_msg, 0);
    wait_load("t2_lat");
    step();

    prog();
    chk("t3_prog", sif.prog_mode, 1);
    chk("t3_shift", sif.shift_en, 0);
    for (int i = 0; i < 4; i++) begin
      wr(vals[i]);
      chk($sformatf("t3_wea%0d", i), sif.wea, 1);
      chk($sformatf("t3_addra%0d", i), sif.addra, i);
      chk($sformatf("t3_dina%0d", i), sif.dina, vals[i]);
      if (i < 3) begin
        chk($sformatf("t3_pm%0d", i), sif.prog_mode, 1);
        step();
        chk($sformatf("t3_pulse%0d", i), sif.wea, 0);
      end
    end
    chk("t3_exit", sif.prog_mode, 0);
    chk("t3_cur", sif.cur_msg, 0);
    chk("t3_addrb", sif.addrb, 0);
    wait_load("t3_lat");
    step();

    ticks(8);
    chk("t4_cur1", sif.cur_msg, 1);
    wait_load("t4_lat");
    step();
    prog();
    wr(16'hAAAA);
    chk("t4_a0", sif.addra, 0);
    step();
    wr(16'hBBBB);
    chk("t4_a1", sif.addra, 1);
    sif.prog_btn  = 1'b1;
    sif.write_btn = 1'b1;
    step();
    sif.prog_btn  = 1'b0;
    sif.write_btn = 1'b0;
    chk("t4_nowea", sif.wea, 0);
    chk("t4_exit", sif.prog_mode, 0);
    chk("t4_cur", sif.cur_msg, 1);
    chk("t4_addrb", sif.addrb, 1);
    prog();
    wr(16'hCCCC);
    chk("t4_restart_wea", sif.wea, 1);
    chk("t4_restart_a", sif.addra, 0);
    prog();
    wait_load("t4_lat2");
    step();

    sif.prog_btn  = 1'b1;
    sif.write_btn = 1'b1;
    step();
    sif.prog_btn  = 1'b0;
    sif.write_btn = 1'b0;
    chk("t5_prog", sif.prog_mode, 1);
    chk("t5_nowea", sif.wea, 0);
    step();
    chk("t5_nowea2", sif.wea, 0);
    sif.write_btn = 1'b1;
    @(posedge clk);
    rst_n = 1'b0;
    #1;
    sif.write_btn = 1'b0;
    chk("t5_rst_wea", sif.wea, 0);
    chk("t5_rst_prog", sif.prog_mode, 0);
    chk("t5_rst_cur", sif.cur_msg, 0);
    step();
    chk("t5_rst_wea2", sif.wea, 0);
    rst_n = 1'b1;
    wait_load("t5_lat");
    step();

`ifdef SCROLL_PAUSE_EN
    ticks(3);
    sif.pause_btn = 1'b1;
    step();
    sif.pause_btn = 1'b0;
    chk("t6_paused", sif.shift_en, 0);
    ticks(5);
    chk("t6_hold", sif.cur_msg, 0);
    chk("t6_hold_sh", sif.shift_en, 0);
    sif.pause_btn = 1'b1;
    step();
    sif.pause_btn = 1'b0;
    chk("t6_resume", sif.shift_en, 1);
    ticks(4);
    chk("t6_cur4", sif.cur_msg, 0);
    ticks(1);
    chk("t6_cur5", sif.cur_msg, 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
